// File: rtl/argmax_result_if.sv
// Score-readback bus for argmax_result: sequencer handshake,
// pixel-memory read port and classification result.
interface argmax_result_if #(
    parameter int SIZE_1           = 12,
    parameter int SIZE_8           = 96,
    parameter int SIZE_address_pix = 13,
    parameter int SIZE_class       = 7
) ();
    logic                        result_en;
    logic [SIZE_address_pix-1:0] memstartp;
    logic [SIZE_class-1:0]       classes;
    logic [SIZE_8-1:0]           qp;
    logic                        re_p;
    logic [SIZE_address_pix-1:0] read_addressp;
    logic [SIZE_class-1:0]       class_idx;
    logic signed [SIZE_1-1:0]    class_val;
    logic                        STOP;

    modport master (
        output result_en, memstartp, classes, qp,
        input  re_p, read_addressp, class_idx, class_val, STOP
    );

    modport slave (
        input  result_en, memstartp, classes, qp,
        output re_p, read_addressp, class_idx, class_val, STOP
    );
endinterface

// File: rtl/argmax_result.sv
// Final classification stage: reads packed class scores back from
// pixel memory and reports the index/value of the highest one.
module argmax_result #(
    parameter int SIZE_1           = 12,
    parameter int SIZE_8           = 96,
    parameter int SIZE_address_pix = 13,
    parameter int SIZE_class       = 7
) (
    input logic            clk,
    input logic            rst,
    argmax_result_if.slave bus
);
    localparam int WW = SIZE_class - 3;

    typedef enum logic [1:0] {IDLE, FETCH, SCAN, DONE} state_t;

    state_t                      state;
    logic                        fcnt;
    logic [WW-1:0]               w;
    logic [2:0]                  l;
    logic [SIZE_8-1:0]           wbuf;
    logic [SIZE_address_pix-1:0] mstart;
    logic [SIZE_class-1:0]       ncls;
    logic [SIZE_class-1:0]       max_idx;
    logic signed [SIZE_1-1:0]    max_val;

    logic signed [SIZE_1-1:0]    lanes [8];
    logic signed [SIZE_1-1:0]    lane;
    logic [SIZE_class-1:0]       idx;
    logic [WW-1:0]               w_inc;
    logic                        last;
    logic                        take;
    logic [SIZE_class-1:0]       nidx;
    logic signed [SIZE_1-1:0]    nval;

    // Lane 0 sits in the MSBs of the packed word.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            lanes[i] = wbuf[SIZE_8-1-i*SIZE_1 -: SIZE_1];
        end
        lane  = lanes[l];
        idx   = {w, l};
        w_inc = w + WW'(1);
        last  = (idx == ncls - SIZE_class'(1));
        take  = (idx == '0) || (lane > max_val);
        nidx  = take ? idx : max_idx;
        nval  = take ? lane : max_val;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            fcnt              <= 1'b0;
            w                 <= '0;
            l                 <= '0;
            wbuf              <= '0;
            mstart            <= '0;
            ncls              <= '0;
            max_idx           <= '0;
            max_val           <= '0;
            bus.re_p          <= 1'b0;
            bus.read_addressp <= '0;
            bus.class_idx     <= '0;
            bus.class_val     <= '0;
            bus.STOP          <= 1'b0;
        end else if (!bus.result_en) begin
            // Abort or end of run: results stay as they were.
            state    <= IDLE;
            bus.re_p <= 1'b0;
            bus.STOP <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    mstart <= bus.memstartp;
                    ncls   <= bus.classes;
                    w      <= '0;
                    l      <= '0;
                    fcnt   <= 1'b0;
                    if (bus.classes == '0) begin
                        bus.class_idx <= '0;
                        bus.class_val <= '0;
                        bus.STOP      <= 1'b1;
                        state         <= DONE;
                    end else begin
                        bus.read_addressp <= bus.memstartp;
                        bus.re_p          <= 1'b1;
                        state             <= FETCH;
                    end
                end
                FETCH: begin
                    if (fcnt) begin
                        wbuf  <= bus.qp;
                        l     <= '0;
                        fcnt  <= 1'b0;
                        state <= SCAN;
                    end else begin
                        fcnt <= 1'b1;
                    end
                end
                SCAN: begin
                    max_idx <= nidx;
                    max_val <= nval;
                    if (last) begin
                        bus.class_idx <= nidx;
                        bus.class_val <= nval;
                        bus.STOP      <= 1'b1;
                        bus.re_p      <= 1'b0;
                        state         <= DONE;
                    end else if (l == 3'd7) begin
                        w                 <= w_inc;
                        bus.read_addressp <= mstart + SIZE_address_pix'(w_inc);
                        state             <= FETCH;
                    end else begin
                        l <= l + 3'd1;
                    end
                end
                DONE: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_argmax_result.sv
// Directed vector bench for argmax_result with a one-cycle
// registered pixel-memory model.
module tb_argmax_result;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    argmax_result_if ifc ();

    argmax_result dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    logic [95:0] mem [256];

    always @(posedge clk) ifc.qp <= mem[ifc.read_addressp[7:0]];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [6:0]         cls;
        logic [12:0]        start;
        logic [95:0]        w0;
        logic [95:0]        w1;
        logic [6:0]         eidx;
        logic signed [11:0] eval;
        int                 eedges;
        int                 nrd;
    } vec_t;

    vec_t v [6];

    task automatic chk(input string nm, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [95:0] pk(input int a0, input int a1,
                                       input int a2, input int a3,
                                       input int a4, input int a5,
                                       input int a6, input int a7);
        return {12'(a0), 12'(a1), 12'(a2), 12'(a3),
                12'(a4), 12'(a5), 12'(a6), 12'(a7)};
    endfunction

    task automatic run(input int k);
        int n;
        int hi;
        logic [12:0] a [$];
        mem[v[k].start[7:0]]        = v[k].w0;
        mem[v[k].start[7:0] + 8'd1] = v[k].w1;
        @(negedge clk);
        ifc.memstartp = v[k].start;
        ifc.classes   = v[k].cls;
        ifc.result_en = 1'b1;
        n  = 0;
        hi = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (ifc.re_p) begin
                hi++;
                if (a.size() == 0 || a[$] !== ifc.read_addressp)
                    a.push_back(ifc.read_addressp);
            end
        end while (!ifc.STOP && n < 100);
        chk($sformatf("v%0d edges", k), n - 1, v[k].eedges);
        chk($sformatf("v%0d idx", k), ifc.class_idx, v[k].eidx);
        chk($sformatf("v%0d val", k), ifc.class_val, v[k].eval);
        chk($sformatf("v%0d re_p_on", k), hi, v[k].eedges);
        chk($sformatf("v%0d re_p_end", k), ifc.re_p, 0);
        chk($sformatf("v%0d nreads", k), a.size(), v[k].nrd);
        if (a.size() > 0)
            chk($sformatf("v%0d addr0", k), a[0], v[k].start);
        if (a.size() > 1)
            chk($sformatf("v%0d addr1", k), a[1], v[k].start + 1);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d stop_hold", k), ifc.STOP, 1);
        @(negedge clk);
        ifc.result_en = 1'b0;
        @(posedge clk);
        #1;
        chk($sformatf("v%0d stop_clr", k), ifc.STOP, 0);
        chk($sformatf("v%0d idx_keep", k), ifc.class_idx, v[k].eidx);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;

        v[0] = '{7'd10, 13'd100,
                 pk(-300, 400, 12, -7, 0, 399, -1, 250),
                 pk(-100, 500, 2047, 2047, 2047, 2047, 2047, 2047),
                 7'd9, 12'sd500, 14, 2};
        v[1] = '{7'd8, 13'd200,
                 pk(-5, -5, -5, 7, -5, -5, 7, -5), '0,
                 7'd3, 12'sd7, 10, 1};
        v[2] = '{7'd3, 13'd40,
                 pk(-1, 4, 2, 2047, 2047, 2047, 2047, 2047), '0,
                 7'd1, 12'sd4, 5, 1};
        v[3] = '{7'd0, 13'd50, pk(9, 9, 9, 9, 9, 9, 9, 9), '0,
                 7'd0, 12'sd0, 0, 0};
        v[4] = '{7'd1, 13'd60,
                 pk(-2048, 2047, 2047, 2047, 2047, 2047, 2047, 2047), '0,
                 7'd0, -12'sd2048, 3, 1};
        v[5] = '{7'd16, 13'd70,
                 pk(-10, -10, -10, -10, -10, 100, -10, -10),
                 pk(0, 0, 0, 0, 0, 0, 0, 100),
                 7'd5, 12'sd100, 20, 2};

        rst           = 1'b1;
        ifc.result_en = 1'b1;
        ifc.memstartp = 13'd5;
        ifc.classes   = 7'd4;
        @(posedge clk);
        #1;
        rst           = 1'b0;
        ifc.result_en = 1'b0;
        chk("rst re_p", ifc.re_p, 0);
        chk("rst addr", ifc.read_addressp, 0);
        chk("rst idx", ifc.class_idx, 0);
        chk("rst val", ifc.class_val, 0);
        chk("rst stop", ifc.STOP, 0);

        for (int k = 0; k < 6; k++) run(k);

        // Complete a run, then abort the next one mid-SCAN.
        run(0);
        mem[200] = v[1].w0;
        @(negedge clk);
        ifc.memstartp = v[1].start;
        ifc.classes   = v[1].cls;
        ifc.result_en = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("abort re_p_mid", ifc.re_p, 1);
        @(negedge clk);
        ifc.result_en = 1'b0;
        @(posedge clk);
        #1;
        chk("abort stop", ifc.STOP, 0);
        chk("abort re_p", ifc.re_p, 0);
        chk("abort idx", ifc.class_idx, 9);
        chk("abort val", ifc.class_val, 500);
        run(1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
